// File: rtl/tmr_err_injector.sv
// TMR fault-injection initiator: pulses inj_err_o and scores the DUT's error flags.
// Optional randomised gap length when TMR_INJ_RAND_EN is defined.
module tmr_err_injector #(
    parameter int L         = 2,
    parameter int K         = 64,
    parameter int PULSE_LEN = 1,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [L-1:0]     err_data_i,
    input  logic [L-1:0]     err_state_i,
    output logic             inj_err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] inj_cnt_o,
    output logic [CNT_W-1:0] det_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] spur_cnt_o,
    output logic [7:0]       last_lat_o,
    output logic [L-1:0]     lane_seen_o
);

    localparam int CW = $clog2(2 * K + PULSE_LEN + TIMEOUT + 1);
    localparam logic [CW-1:0] KM1     = CW'(K - 1);
    localparam logic [CW-1:0] PL_LAST = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, INJECT, DETECT} state_t;

    state_t state_q, state_d, after_win;

    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    gap_last;
    logic [7:0]       lat_q;
    logic             hit_q;
    logic             stop_q;
    logic             inj_q;
    logic             busy_q;
    logic [CNT_W-1:0] inj_cnt_q, det_cnt_q, miss_cnt_q, spur_cnt_q;
    logic [7:0]       last_lat_q;
    logic [L-1:0]     lane_q;
    logic [L-1:0]     err_vec;
    logic             err_any;
    logic             inj_ev, det_ev, miss_ev, spur_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign err_vec = err_data_i | err_state_i;
    assign err_any = |err_vec;

`ifdef TMR_INJ_RAND_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else if (inj_ev) begin
            lfsr_q <= {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign gap_last = KM1 + (CW'(lfsr_q) & KM1);
`else
    assign gap_last = KM1;
`endif

    // a disable seen at any point of an injection sends us home afterwards
    assign after_win = (stop_q || !en_i) ? IDLE : WAIT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        inj_ev  = 1'b0;
        det_ev  = 1'b0;
        miss_ev = 1'b0;
        spur_ev = 1'b0;
        case (state_q)
            IDLE: begin
                spur_ev = err_any;
                if (en_i) state_d = WAIT;
            end
            WAIT: begin
                spur_ev = err_any;
                if (!en_i) begin
                    state_d = IDLE;
                end else if (cnt_q == gap_last) begin
                    state_d = INJECT;
                    inj_ev  = 1'b1;
                end
            end
            INJECT: begin
                det_ev = err_any && !hit_q;
                if (cnt_q == PL_LAST)
                    state_d = (hit_q || det_ev) ? after_win : DETECT;
            end
            DETECT: begin
                if (err_any) begin
                    det_ev  = 1'b1;
                    state_d = after_win;
                end else if (cnt_q == TO_LAST) begin
                    miss_ev = 1'b1;
                    state_d = after_win;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            lat_q      <= '0;
            hit_q      <= 1'b0;
            stop_q     <= 1'b0;
            inj_q      <= 1'b0;
            busy_q     <= 1'b0;
            inj_cnt_q  <= '0;
            det_cnt_q  <= '0;
            miss_cnt_q <= '0;
            spur_cnt_q <= '0;
            last_lat_q <= '0;
            lane_q     <= '0;
        end else begin
            if (state_d != state_q || state_d == IDLE) cnt_q <= '0;
            else                                       cnt_q <= cnt_q + CW'(1);
            if (inj_ev)      lat_q <= '0;
            else if (~&lat_q) lat_q <= lat_q + 8'd1;
            if (inj_ev)      hit_q <= 1'b0;
            else if (det_ev) hit_q <= 1'b1;
            if (state_d == IDLE || state_d == WAIT) stop_q <= 1'b0;
            else                                    stop_q <= stop_q || !en_i;
            inj_q  <= (state_d == INJECT);
            busy_q <= (state_d != IDLE);
            if (inj_ev)  inj_cnt_q  <= sat_inc(inj_cnt_q);
            if (miss_ev) miss_cnt_q <= sat_inc(miss_cnt_q);
            if (spur_ev) spur_cnt_q <= sat_inc(spur_cnt_q);
            if (det_ev) begin
                det_cnt_q  <= sat_inc(det_cnt_q);
                last_lat_q <= lat_q;
                lane_q     <= lane_q | err_vec;
            end
        end
    end

    assign inj_err_o   = inj_q;
    assign busy_o      = busy_q;
    assign inj_cnt_o   = inj_cnt_q;
    assign det_cnt_o   = det_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign spur_cnt_o  = spur_cnt_q;
    assign last_lat_o  = last_lat_q;
    assign lane_seen_o = lane_q;

endmodule

// File: tb/tb_tmr_err_injector.sv
// Scoreboard bench for tmr_err_injector: directed flag timing, queued
// expectations, monitor checks every inj_err_o edge and counter change.
module tb_tmr_err_injector;

    localparam int L  = 2;
    localparam int K  = 16;
    localparam int PL = 4;
    localparam int TO = 16;
    localparam int CW = 16;
`ifdef TMR_INJ_RAND_EN
    localparam int JIT = K - 1;
`else
    localparam int JIT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          en;
    logic [L-1:0]  err_data;
    logic [L-1:0]  err_state;
    logic          inj_err;
    logic          busy;
    logic [CW-1:0] inj_cnt, det_cnt, miss_cnt, spur_cnt;
    logic [7:0]    last_lat;
    logic [L-1:0]  lane_seen;

    tmr_err_injector #(
        .L(L), .K(K), .PULSE_LEN(PL), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en),
        .err_data_i(err_data), .err_state_i(err_state),
        .inj_err_o(inj_err), .busy_o(busy),
        .inj_cnt_o(inj_cnt), .det_cnt_o(det_cnt),
        .miss_cnt_o(miss_cnt), .spur_cnt_o(spur_cnt),
        .last_lat_o(last_lat), .lane_seen_o(lane_seen)
    );

    always #5 clk = ~clk;

    typedef struct {bit rel; int refc; int lo; int hi; int inj;} rise_t;
    typedef struct {int det; int lat; int lane;} det_t;

    rise_t rq[$];
    det_t  dq[$];
    int    mq[$];
    int    sq[$];

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic unexpected(input string nm, input int act);
        total++;
        $display("FAIL %s: unexpected event, value %0d, expected none", nm, act);
    endtask

    task automatic push_rise(input bit rel, input int refc, input int base, input int n);
        rq.push_back('{rel, refc, base, base + JIT, n});
    endtask

    task automatic wait_rise(input string nm);
        int n;
        n = 0;
        while (inj_err === 1'b1 && n < 200) begin @(negedge clk); n++; end
        while (inj_err !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        if (inj_err !== 1'b1) begin
            total++;
            $display("FAIL %s: no inj_err_o rise within bound, got 0, expected 1", nm);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_inj"},   int'(inj_err),   0);
        chk({nm, "_busy"},  int'(busy),      0);
        chk({nm, "_ninj"},  int'(inj_cnt),   0);
        chk({nm, "_ndet"},  int'(det_cnt),   0);
        chk({nm, "_nmiss"}, int'(miss_cnt),  0);
        chk({nm, "_nspur"}, int'(spur_cnt),  0);
        chk({nm, "_lat"},   int'(last_lat),  0);
        chk({nm, "_lane"},  int'(lane_seen), 0);
    endtask

    // monitor: every observable event pops one queued expectation
    logic          p_inj;
    logic [CW-1:0] p_det, p_miss, p_spur;
    int            last_rise = 0;

    always @(negedge clk) begin
        rise_t r;
        det_t  d;
        int    m;
        if (rst_ni !== 1'b1) begin
            p_inj  = inj_err;
            p_det  = det_cnt;
            p_miss = miss_cnt;
            p_spur = spur_cnt;
        end else begin
            if (inj_err && !p_inj) begin
                if (rq.size() == 0) begin
                    unexpected("rise", int'(inj_cnt));
                end else begin
                    r = rq.pop_front();
                    chk_rng("rise_gap", r.rel ? cyc - last_rise : cyc - r.refc, r.lo, r.hi);
                    chk("rise_inj_cnt", int'(inj_cnt), r.inj);
                end
                last_rise = cyc;
            end
            if (!inj_err && p_inj) chk("pulse_len", cyc - last_rise, PL);
            if (det_cnt != p_det) begin
                if (dq.size() == 0) begin
                    unexpected("det", int'(det_cnt));
                end else begin
                    d = dq.pop_front();
                    chk("det_cnt", int'(det_cnt), d.det);
                    chk("last_lat", int'(last_lat), d.lat);
                    chk("lane_seen", int'(lane_seen), d.lane);
                end
            end
            if (miss_cnt != p_miss) begin
                if (mq.size() == 0) unexpected("miss", int'(miss_cnt));
                else begin m = mq.pop_front(); chk("miss_cnt", int'(miss_cnt), m); end
            end
            if (spur_cnt != p_spur) begin
                if (sq.size() == 0) unexpected("spur", int'(spur_cnt));
                else begin m = sq.pop_front(); chk("spur_cnt", int'(spur_cnt), m); end
            end
            p_inj  = inj_err;
            p_det  = det_cnt;
            p_miss = miss_cnt;
            p_spur = spur_cnt;
        end
    end

    initial begin
        int c;
        rst_ni    = 1'b0;
        en        = 1'b0;
        err_data  = '0;
        err_state = '0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // first injection, lane 0 state flag at latency 3, then a spurious burst
        en = 1'b1;
        c  = cyc;
        push_rise(1'b0, c, K + 1, 1);
        wait_rise("rise1");
        repeat (3) @(negedge clk);
        err_state = 2'b01;
        dq.push_back('{1, 3, 1});
        @(negedge clk);
        err_state = '0;
        for (int i = 1; i <= 5; i++) sq.push_back(i);
        @(negedge clk);
        err_data = 2'b10;
        repeat (5) @(negedge clk);
        err_data = '0;

        // flag on the 2nd pulse cycle
        push_rise(1'b1, 0, PL + K, 2);
        wait_rise("rise2");
        @(negedge clk);
        err_data = 2'b10;
        dq.push_back('{2, 1, 3});
        @(negedge clk);
        err_data = '0;

        // flag inside the detection window
        push_rise(1'b1, 0, PL + K, 3);
        wait_rise("rise3");
        repeat (6) @(negedge clk);
        err_state = 2'b10;
        dq.push_back('{3, 6, 3});
        @(negedge clk);
        err_state = '0;

        // four silent injections, disable during the last window
        for (int i = 1; i <= 4; i++) mq.push_back(i);
        push_rise(1'b1, 0, 7 + K, 4);
        wait_rise("rise4");
        push_rise(1'b1, 0, PL + TO + K, 5);
        wait_rise("rise5");
        push_rise(1'b1, 0, PL + TO + K, 6);
        wait_rise("rise6");
        push_rise(1'b1, 0, PL + TO + K, 7);
        wait_rise("rise7");
        repeat (8) @(negedge clk);
        en = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_inj", int'(inj_err), 0);
        chk("final_inj_cnt", int'(inj_cnt), 7);
        chk("final_det_cnt", int'(det_cnt), 3);
        chk("final_miss_cnt", int'(miss_cnt), 4);
        chk("final_spur_cnt", int'(spur_cnt), 5);
        chk("final_lane", int'(lane_seen), 3);
        chk("final_lat", int'(last_lat), 6);

        // asynchronous reset in the middle of a pulse
        en = 1'b1;
        c  = cyc;
        push_rise(1'b0, c, K + 1, 8);
        wait_rise("rise8");
        chk("pre_rst_inj", int'(inj_err), 1);
        #2 rst_ni = 1'b0;
        #1;
        check_zero("midrst");
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("rq_drained", rq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        chk("mq_drained", mq.size(), 0);
        chk("sq_drained", sq.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
